nttn_host_driver: RTL and testbench

Command-driven initiator for the NTTN serial load/start/unload protocol. Turns single host commands (load twiddles, run NTT, run INTT) into the exact pulse and stream sequences NTTN expects. Twiddles, parameters and coefficients are read from a host word memory, and NTTN results are written back to it. Sits between the system interconnect and NTTN.

---
 rtl/nttn_host_driver_pkg.sv | 42 ++++
 rtl/nttn_host_driver_if.sv | 33 +++
 rtl/nttn_host_stream.sv | 47 ++++
 rtl/nttn_host_driver.sv | 116 +++++++++++
 tb/tb_nttn_host_driver.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nttn_host_driver_pkg.sv
// Shared encodings for the NTTN host driver: opcodes, FSM states and ring-size helpers.
// Falls back to local defaults when the project defines.v has not been read first.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif
`ifndef RING_DEPTH
`define RING_DEPTH 8
`endif
`ifndef PE_DEPTH
`define PE_DEPTH 3
`endif

package nttn_host_driver_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_TW = 2'b00,
        OP_NTT     = 2'b01,
        OP_INTT    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_STREAM,
        S_GAP,
        S_START,
        S_WAIT_DONE,
        S_CAPTURE,
        S_RESP
    } state_e;

    // Number of twiddle words NTTN expects for one direction (W or WINV).
    function automatic int unsigned tw_words(input int ring_depth, input int pe_depth);
        return (((1 << (ring_depth - pe_depth)) - 1) + pe_depth) << pe_depth;
    endfunction

    function automatic int unsigned n_words(input int ring_depth);
        return 1 << ring_depth;
    endfunction

endpackage

// File: rtl/nttn_host_driver_if.sv
// Bundle of command, response, host-memory and NTTN pins around the host driver.
// master = the driver itself, slave = interconnect / memory / NTTN side.
interface nttn_host_driver_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_W    = 16
);
    logic                 cmd_valid, cmd_ready;
    logic [1:0]           cmd_op;
    logic [ADDR_W-1:0]    cmd_src, cmd_dst;
    logic                 rsp_valid, rsp_err;
    logic                 mem_rd;
    logic [ADDR_W-1:0]    mem_raddr;
    logic [DATA_SIZE-1:0] mem_rdata;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_waddr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic                 load_w, load_data, start, start_intt;
    logic [DATA_SIZE-1:0] din;
    logic                 done;
    logic [DATA_SIZE-1:0] dout;

    modport master (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, mem_rdata, done, dout,
        output cmd_ready, rsp_valid, rsp_err, mem_rd, mem_raddr, mem_we, mem_waddr,
               mem_wdata, load_w, load_data, start, start_intt, din
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, mem_rdata, done, dout,
        input  cmd_ready, rsp_valid, rsp_err, mem_rd, mem_raddr, mem_we, mem_waddr,
               mem_wdata, load_w, load_data, start, start_intt, din
    );
endinterface

// File: rtl/nttn_host_stream.sv
// Address counter plus one-cycle read pipeline feeding din; used for twiddle and data streams.
// The first read is issued combinationally in the kick cycle so din lines up one cycle after the pulse.
module nttn_host_stream #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_W    = 16,
    parameter int LEN_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 kick,
    input  logic [ADDR_W-1:0]    base,
    input  logic [LEN_W-1:0]     len,
    input  logic [DATA_SIZE-1:0] rdata,
    output logic                 rd,
    output logic [ADDR_W-1:0]    raddr,
    output logic [DATA_SIZE-1:0] din
);
    logic              active, rd_q;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  left;

    assign rd    = kick || active;
    assign raddr = kick ? base : (active ? ptr : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            rd_q   <= 1'b0;
            ptr    <= '0;
            left   <= '0;
            din    <= '0;
        end else begin
            rd_q <= rd;
            if (rd_q) din <= rdata;
            // Pointer wraps naturally modulo 2^ADDR_W.
            if (kick) begin
                ptr    <= base + ADDR_W'(1);
                left   <= len - LEN_W'(1);
                active <= (len > LEN_W'(1));
            end else if (active) begin
                ptr    <= ptr + ADDR_W'(1);
                left   <= left - LEN_W'(1);
                active <= (left != LEN_W'(1));
            end
        end
    end
endmodule

// File: rtl/nttn_host_driver.sv
// Command-driven initiator for the NTTN load/start/unload protocol.
// Optional WAIT_DONE watchdog enabled by defining NTTN_HOST_TIMEOUT_EN.
module nttn_host_driver
    import nttn_host_driver_pkg::*;
#(
    parameter int DATA_SIZE  = `DATA_SIZE_ARB,
    parameter int RING_DEPTH = `RING_DEPTH,
    parameter int PE_DEPTH   = `PE_DEPTH,
    parameter int ADDR_W     = 16,
    parameter int GAP        = 5,
    parameter int TIMEOUT    = 1 << 20
) (
    input logic                clk,
    input logic                reset,
    nttn_host_driver_if.master bus
);
    localparam int unsigned TW     = tw_words(RING_DEPTH, PE_DEPTH);
    localparam int unsigned N      = n_words(RING_DEPTH);
    localparam int unsigned TW_LEN = 2 * TW + 2;
    localparam int          CNT_W  = 32;

    state_e            state, state_n;
    op_e               op_q;
    logic              err_q, tw_loaded, settle;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  cnt, len, stream_last;
    logic              cmd_fire, cmd_bad, kick, timeout;

    assign cmd_fire    = bus.cmd_valid && (state == S_IDLE);
    assign cmd_bad     = (bus.cmd_op == OP_ILLEGAL) || ((bus.cmd_op != OP_LOAD_TW) && !tw_loaded);
    assign kick        = cmd_fire && !cmd_bad;
    assign len         = (bus.cmd_op == OP_LOAD_TW) ? CNT_W'(TW_LEN) : CNT_W'(N);
    assign stream_last = (op_q == OP_LOAD_TW) ? CNT_W'(TW_LEN - 1) : CNT_W'(N - 1);

`ifdef NTTN_HOST_TIMEOUT_EN
    // cnt is 1 on the first cycle done is actually sampled.
    assign timeout = (state == S_WAIT_DONE) && !settle && !bus.done && (cnt >= CNT_W'(TIMEOUT));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout        = 1'b0;
`endif

    nttn_host_stream #(.DATA_SIZE(DATA_SIZE), .ADDR_W(ADDR_W), .LEN_W(CNT_W)) u_stream (
        .clk   (clk),
        .rst_n (reset),
        .kick  (kick),
        .base  (bus.cmd_src),
        .len   (len),
        .rdata (bus.mem_rdata),
        .rd    (bus.mem_rd),
        .raddr (bus.mem_raddr),
        .din   (bus.din)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:      if (cmd_fire) state_n = S_PULSE;
            S_PULSE:     state_n = err_q ? S_RESP : S_STREAM;
            S_STREAM:    if (cnt == stream_last) state_n = S_GAP;
            S_GAP:       if (cnt == CNT_W'(GAP - 1)) state_n = (op_q == OP_LOAD_TW) ? S_RESP : S_START;
            S_START:     state_n = S_WAIT_DONE;
            S_WAIT_DONE: if (!settle && bus.done) state_n = S_CAPTURE;
                         else if (timeout)        state_n = S_RESP;
            S_CAPTURE:   if (cnt == CNT_W'(N - 1)) state_n = S_RESP;
            S_RESP:      state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready  = (state == S_IDLE);
        bus.load_w     = (state == S_PULSE) && !err_q && (op_q == OP_LOAD_TW);
        bus.load_data  = (state == S_PULSE) && !err_q && (op_q != OP_LOAD_TW);
        bus.start      = (state == S_START) && (op_q == OP_NTT);
        bus.start_intt = (state == S_START) && (op_q == OP_INTT);
        bus.rsp_valid  = (state == S_RESP);
        bus.rsp_err    = (state == S_RESP) && err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            settle        <= 1'b0;
            op_q          <= OP_LOAD_TW;
            err_q         <= 1'b0;
            dst_q         <= '0;
            tw_loaded     <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
        end else begin
            cnt    <= (state_n != state) ? '0 : cnt + CNT_W'(1);
            // The cycle right after start is a mandatory idle; done is not looked at there.
            settle <= (state == S_START);
            if (cmd_fire) begin
                op_q  <= op_e'(bus.cmd_op);
                err_q <= cmd_bad;
                dst_q <= bus.cmd_dst;
            end
            if (timeout) err_q <= 1'b1;
            if ((state == S_RESP) && !err_q && (op_q == OP_LOAD_TW)) tw_loaded <= 1'b1;
            bus.mem_we <= (state == S_CAPTURE);
            if (state == S_CAPTURE) begin
                bus.mem_waddr <= dst_q + ADDR_W'(cnt);
                bus.mem_wdata <= bus.dout;
            end
        end
    end
endmodule

// File: tb/tb_nttn_host_driver.sv
// Self-checking bench for nttn_host_driver with a behavioural host memory and NTTN model.
// Timeout scenario is compiled only when NTTN_HOST_TIMEOUT_EN is defined.
module tb_nttn_host_driver;
    localparam int N    = 16;
    localparam int TW   = 16;
    localparam int LTW  = 2 * TW + 2;
    localparam int GAPC = 5;
    localparam int TMO  = 100;
    localparam int DLY  = 50;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    logic [31:0] mem [0:65535];

    always #5 clk = ~clk;

    nttn_host_driver_if #(.DATA_SIZE(32), .ADDR_W(16)) bus ();

    nttn_host_driver #(
        .DATA_SIZE(32), .RING_DEPTH(4), .PE_DEPTH(1), .ADDR_W(16), .GAP(GAPC), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Host memory: read data valid the cycle after the request.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_raddr];
        if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
    end

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] src, input logic [15:0] dst);
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL cmd_ready_idle got=%b want=1", bus.cmd_ready);
        else passes++;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_src   = src;
        bus.cmd_dst   = dst;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.mem_rd, bus.mem_we, bus.load_w,
             bus.load_data, bus.start, bus.start_intt} !== 9'b1_0000_0000)
            $display("FAIL reset_ctrl got=%b want=100000000", {bus.cmd_ready, bus.rsp_valid,
                     bus.rsp_err, bus.mem_rd, bus.mem_we, bus.load_w, bus.load_data, bus.start,
                     bus.start_intt});
        else passes++;
        checks++;
        if ({bus.din, bus.mem_raddr, bus.mem_waddr, bus.mem_wdata} !== '0)
            $display("FAIL reset_data din=%h raddr=%h waddr=%h wdata=%h want=0", bus.din,
                     bus.mem_raddr, bus.mem_waddr, bus.mem_wdata);
        else passes++;
        reset = 1'b1;
    endtask

    task automatic test_illegal(input logic [1:0] op);
        logic [31:0] din0;
        din0 = bus.din;
        send_cmd(op, 16'h0500, 16'h0600);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            checks++;
            if ({bus.load_w, bus.load_data, bus.start, bus.start_intt, bus.mem_we} !== 5'b0)
                $display("FAIL illegal_pins j=%0d got=%b want=00000", j,
                         {bus.load_w, bus.load_data, bus.start, bus.start_intt, bus.mem_we});
            else passes++;
            checks++;
            if (bus.din !== din0) $display("FAIL illegal_din j=%0d got=%h want=%h", j, bus.din, din0);
            else passes++;
            checks++;
            if (bus.rsp_valid !== (j == 2) || (j == 2 && bus.rsp_err !== 1'b1))
                $display("FAIL illegal_rsp j=%0d valid=%b err=%b want valid=%b err=1", j,
                         bus.rsp_valid, bus.rsp_err, (j == 2));
            else passes++;
            if (j == 1) bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic test_load_tw(input logic [15:0] src);
        logic [15:0] a;
        send_cmd(2'b00, src, 16'h0000);
        for (int j = 1; j <= LTW + GAPC + 4; j++) begin
            @(negedge clk);
            checks++;
            if ({bus.load_w, bus.load_data, bus.start, bus.start_intt} !== {(j == 1), 3'b000})
                $display("FAIL load_pulses j=%0d got=%b want=%b", j,
                         {bus.load_w, bus.load_data, bus.start, bus.start_intt}, {(j == 1), 3'b000});
            else passes++;
            if (j >= 2 && j <= LTW + GAPC + 1) begin
                // Words stream from src upward, then the last one holds through the gap.
                a = (j <= LTW + 1) ? src + 16'(j - 2) : src + 16'(LTW - 1);
                checks++;
                if (bus.din !== mem[a]) $display("FAIL load_din j=%0d got=%h want=%h", j, bus.din, mem[a]);
                else passes++;
            end
            checks++;
            if (bus.rsp_valid !== (j == LTW + GAPC + 2) || (bus.rsp_valid && bus.rsp_err !== 1'b0))
                $display("FAIL load_rsp j=%0d valid=%b err=%b want valid=%b err=0", j,
                         bus.rsp_valid, bus.rsp_err, (j == LTW + GAPC + 2));
            else passes++;
            checks++;
            if (bus.mem_we !== 1'b0) $display("FAIL load_we j=%0d got=%b want=0", j, bus.mem_we);
            else passes++;
            if (j == 1) bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic test_run(input logic [1:0] op, input logic [15:0] src, input logic [15:0] dst);
        logic [31:0] vals [N];
        logic [15:0] a;
        int s_cyc, d_cyc, n_rsp, rsp_j, k;
        logic rsp_e;
        foreach (vals[i]) vals[i] = $urandom;
        s_cyc = N + GAPC + 2;
        d_cyc = s_cyc + DLY;
        n_rsp = 0;
        rsp_j = 0;
        rsp_e = 1'b0;
        send_cmd(op, src, dst);
        for (int j = 1; j <= d_cyc + N + 6; j++) begin
            @(negedge clk);
            checks++;
            if ({bus.load_w, bus.load_data, bus.start, bus.start_intt} !==
                {1'b0, (j == 1), (j == s_cyc && op == 2'b01), (j == s_cyc && op == 2'b10)})
                $display("FAIL run_pulses op=%0d j=%0d got=%b", op, j,
                         {bus.load_w, bus.load_data, bus.start, bus.start_intt});
            else passes++;
            if (j >= 2 && j <= N + GAPC + 1) begin
                a = (j <= N + 1) ? src + 16'(j - 2) : src + 16'(N - 1);
                checks++;
                if (bus.din !== mem[a]) $display("FAIL run_din j=%0d got=%h want=%h", j, bus.din, mem[a]);
                else passes++;
            end
            if (j >= d_cyc + 2 && j < d_cyc + 2 + N) begin
                k = j - d_cyc - 2;
                checks++;
                if ({bus.mem_we, bus.mem_waddr, bus.mem_wdata} !== {1'b1, dst + 16'(k), vals[k]})
                    $display("FAIL run_write j=%0d we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                             j, bus.mem_we, bus.mem_waddr, bus.mem_wdata, dst + 16'(k), vals[k]);
                else passes++;
            end else begin
                checks++;
                if (bus.mem_we !== 1'b0) $display("FAIL run_we_idle j=%0d got=%b want=0", j, bus.mem_we);
                else passes++;
            end
            if (bus.rsp_valid === 1'b1) begin
                n_rsp++;
                rsp_j = j;
                rsp_e = bus.rsp_err;
            end
            if (j == 1) bus.cmd_valid = 1'b0;
            // NTTN model: spurious done mid-stream, real done DLY cycles after start, then N words.
            bus.done = (j == d_cyc) || (j == 10);
            if (j >= d_cyc + 1 && j < d_cyc + 1 + N) bus.dout = vals[j - d_cyc - 1];
            else bus.dout = $urandom;
        end
        bus.done = 1'b0;
        checks++;
        if (n_rsp != 1 || rsp_e !== 1'b0 || rsp_j < d_cyc + N + 1 || rsp_j > d_cyc + N + 2)
            $display("FAIL run_rsp op=%0d count=%0d err=%b at=%0d want count=1 err=0 at %0d..%0d",
                     op, n_rsp, rsp_e, rsp_j, d_cyc + N + 1, d_cyc + N + 2);
        else passes++;
    endtask

`ifdef NTTN_HOST_TIMEOUT_EN
    task automatic test_timeout;
        int s_cyc, n_rsp, rsp_j;
        logic rsp_e;
        s_cyc = N + GAPC + 2;
        n_rsp = 0;
        rsp_j = 0;
        rsp_e = 1'b0;
        bus.done = 1'b0;
        send_cmd(2'b01, 16'h0700, 16'h0800);
        for (int j = 1; j <= s_cyc + TMO + 6; j++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_we !== 1'b0) $display("FAIL timeout_we j=%0d got=%b want=0", j, bus.mem_we);
            else passes++;
            if (bus.rsp_valid === 1'b1) begin
                n_rsp++;
                rsp_j = j;
                rsp_e = bus.rsp_err;
            end
            if (j == 1) bus.cmd_valid = 1'b0;
        end
        checks++;
        if (n_rsp != 1 || rsp_e !== 1'b1 || rsp_j < s_cyc + 1 + TMO || rsp_j > s_cyc + 3 + TMO)
            $display("FAIL timeout_rsp count=%0d err=%b at=%0d want count=1 err=1 at %0d..%0d",
                     n_rsp, rsp_e, rsp_j, s_cyc + 1 + TMO, s_cyc + 3 + TMO);
        else passes++;
    endtask
`endif

    task automatic test_async_reset;
        send_cmd(2'b00, 16'h0100, 16'h0000);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 1) bus.cmd_valid = 1'b0;
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.mem_rd, bus.mem_we, bus.load_w,
             bus.load_data, bus.start, bus.start_intt} !== 9'b1_0000_0000)
            $display("FAIL areset_ctrl got=%b want=100000000", {bus.cmd_ready, bus.rsp_valid,
                     bus.rsp_err, bus.mem_rd, bus.mem_we, bus.load_w, bus.load_data, bus.start,
                     bus.start_intt});
        else passes++;
        checks++;
        if ({bus.din, bus.mem_raddr, bus.mem_waddr, bus.mem_wdata} !== '0)
            $display("FAIL areset_data din=%h raddr=%h waddr=%h wdata=%h want=0", bus.din,
                     bus.mem_raddr, bus.mem_waddr, bus.mem_wdata);
        else passes++;
        @(negedge clk);
        reset = 1'b1;
        // Twiddle state was wiped, so a data command must be refused.
        test_illegal(2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        bus.done      = 1'b0;
        bus.dout      = '0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        test_reset();
        test_illegal(2'b01);
        test_illegal(2'b11);
        test_load_tw(16'h0100);
        test_run(2'b01, 16'h0200, 16'h0300);
        test_run(2'b10, 16'h0210, 16'h0310);
        test_run(2'b01, 16'hFFF8, 16'h0400);
`ifdef NTTN_HOST_TIMEOUT_EN
        test_timeout();
        test_run(2'b10, 16'h0220, 16'h0320);
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
